conv_window_ctrl: RTL and testbench

- Sits between the raw pixel stream and the 3x3 convolution pipeline; receives one 8-bit pixel per cycle.
- Buffers incoming lines in four rotating line buffers. Once three lines are resident, issues 3x3 windows as a flattened 72-bit word with a valid strobe.
- Frees a buffer after each completed output line and signals the frame-level sequencer with a one-cycle interrupt pulse.
- Applies input back-pressure when all four buffers are occupied.

---
 rtl/conv_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_ctrl
//  Description : Line-buffer controller for a 3x3 convolution pipeline.
//                Collects an 8-bit pixel stream into four rotating line
//                buffers. Once three lines are resident it issues flattened
//                72-bit 3x3 windows, frees a buffer per finished output line
//                and pulses an interrupt. Back-pressures the input when all
//                four buffers hold unread lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic        o_pixel_ready,
    input  logic        i_window_ready,
    output logic [71:0] o_window_data,
    output logic        o_window_data_valid,
    output logic        o_intr
);

    // Column counters address one pixel of a line.
    localparam int              CW            = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST_WR_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]   C_LAST_RD_COL = CW'(IMG_WIDTH - 3);
    localparam logic [2:0]      C_LINES_ALL   = 3'd4;
    localparam logic [2:0]      C_LINES_WIN   = 3'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t             r_state;

    // Four line buffers; contents survive reset on purpose.
    logic [7:0]         r_mem [4][IMG_WIDTH];

    logic [CW-1:0]      r_wr_col;
    logic [1:0]         r_wr_sel;
    logic [CW-1:0]      r_rd_col;
    logic [1:0]         r_rd_sel;
    logic [2:0]         r_lines_full;

    logic               w_accept;
    logic               w_issue;
    logic               w_wr_line_done;
    logic               w_rd_line_done;
    logic [2:0]         w_lines_next;

    logic [1:0]         w_row_sel [3];
    logic [CW-1:0]      w_col     [3];
    logic [71:0]        w_window;

    // ------------------------------------------------------------------------
    // Handshake and line-completion decode
    // ------------------------------------------------------------------------
    assign o_pixel_ready  = (r_lines_full != C_LINES_ALL);
    assign w_accept       = i_pixel_data_valid && o_pixel_ready;
    assign w_wr_line_done = w_accept && (r_wr_col == C_LAST_WR_COL);
    assign w_issue        = (r_state == S_READ) && i_window_ready;
    assign w_rd_line_done = w_issue && (r_rd_col == C_LAST_RD_COL);

    // Occupancy after this cycle: a simultaneous fill and free cancel out.
    assign w_lines_next   = r_lines_full
                          + {2'b00, w_wr_line_done}
                          - {2'b00, w_rd_line_done};

    // ------------------------------------------------------------------------
    // Window gather: three consecutive buffers starting at the read select,
    // three consecutive columns starting at the read column.
    // ------------------------------------------------------------------------
    for (genvar gc = 0; gc < 3; gc++) begin : g_col_addr
        assign w_col[gc] = r_rd_col + CW'(gc);
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        assign w_row_sel[gr] = r_rd_sel + 2'(gr);
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign w_window[(gr*3+gc)*8 +: 8] = r_mem[w_row_sel[gr]][w_col[gc]];
        end
    end

    // Store each accepted pixel; only the buffer outside the read rows is hit.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_sel][r_wr_col] <= i_pixel_data;
        end
    end

    // Write pointer: advance the column, rotate to the next buffer at line end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_col <= '0;
            r_wr_sel <= 2'd0;
        end else if (w_accept) begin
            if (w_wr_line_done) begin
                r_wr_col <= '0;
                r_wr_sel <= r_wr_sel + 2'd1;
            end else begin
                r_wr_col <= r_wr_col + CW'(1);
            end
        end
    end

    // Count of buffers holding a complete line not yet fully consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lines_full <= 3'd0;
        end else begin
            r_lines_full <= w_lines_next;
        end
    end

    // Read FSM: issues windows, retires lines and registers all outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state             <= S_IDLE;
            r_rd_col            <= '0;
            r_rd_sel            <= 2'd0;
            o_window_data       <= '0;
            o_window_data_valid <= 1'b0;
            o_intr              <= 1'b0;
        end else begin
            o_window_data_valid <= 1'b0;
            o_intr              <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_lines_full >= C_LINES_WIN) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        o_window_data       <= w_window;
                        o_window_data_valid <= 1'b1;
                        if (w_rd_line_done) begin
                            r_rd_col <= '0;
                            r_rd_sel <= r_rd_sel + 2'd1;
                            o_intr   <= 1'b1;
                            // Keep streaming into the next line when it is
                            // already resident; otherwise wait for a fill.
                            if (w_lines_next < C_LINES_WIN) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_rd_col <= r_rd_col + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_ctrl
//  Description : Self-checking bench for conv_window_ctrl (IMG_WIDTH = 8).
//                A reference model tracks the pixel stream as a flat array
//                and derives every window, interrupt and ready value from
//                line arithmetic on that array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

    localparam int W   = 8;
    localparam int WPL = W - 2;   // windows per output line

    logic        clk;
    logic        rst;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        win_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        intr;

    conv_window_ctrl #(.IMG_WIDTH(W)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_pixel_data        (pix_data),
        .i_pixel_data_valid  (pix_valid),
        .o_pixel_ready       (pix_ready),
        .i_window_ready      (win_ready),
        .o_window_data       (win_data),
        .o_window_data_valid (win_valid),
        .o_intr              (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit test_done = 1'b0;
    bit rnd_done  = 1'b0;

    // Observed window log (cleared by reset)
    logic [71:0] log_data[$];
    int          log_cyc[$];
    int          intr_cnt;
    int          line3_cyc;

    // Reference model state
    byte unsigned m_stream[$];
    int           m_issued;
    int           m_lines;
    bit           m_active;
    logic         m_valid;
    logic         m_intr;
    logic [71:0]  m_data;
    int           m_both;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pack9(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5,
                                          input int b6, input int b7, input int b8);
        return {b8[7:0], b7[7:0], b6[7:0], b5[7:0], b4[7:0],
                b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            m_stream.delete();
            log_data.delete();
            log_cyc.delete();
            m_issued  = 0;
            m_lines   = 0;
            m_active  = 1'b0;
            m_valid   = 1'b0;
            m_intr    = 1'b0;
            m_data    = '0;
            intr_cnt  = 0;
            line3_cyc = -1;
        end else begin
            bit acc, issue, wr_done, rd_done;
            int new_lines, ln, col, idx;
            // Outputs produced by the last rising edge
            check_eq("win_valid", win_valid, m_valid);
            check_eq("intr", intr, m_intr);
            check_eq("win_data", win_data, m_data);
            check_eq("pix_ready", pix_ready, m_lines != 4);
            if (win_valid) begin
                log_data.push_back(win_data);
                log_cyc.push_back(cyc);
            end
            if (intr) intr_cnt++;
            // Predict the next rising edge
            acc     = pix_valid && (m_lines != 4);
            issue   = m_active && win_ready;
            wr_done = acc && ((m_stream.size() % W) == W - 1);
            rd_done = issue && ((m_issued % WPL) == WPL - 1);
            if (wr_done && rd_done) m_both++;
            if (acc) begin
                m_stream.push_back(pix_data);
                if (m_stream.size() == 3 * W && line3_cyc < 0) line3_cyc = cyc;
            end
            if (issue) begin
                ln  = m_issued / WPL;
                col = m_issued % WPL;
                for (int r = 0; r < 3; r++) begin
                    for (int j = 0; j < 3; j++) begin
                        idx = (ln + r) * W + col + j;
                        if (idx < m_stream.size()) m_data[(r*3+j)*8 +: 8] = m_stream[idx];
                        else                       m_data[(r*3+j)*8 +: 8] = 8'hxx;
                    end
                end
                m_issued++;
            end
            m_valid   = issue;
            m_intr    = rd_done;
            new_lines = m_lines + int'(wr_done) - int'(rd_done);
            if (!m_active)                     m_active = (m_lines >= 3);
            else if (rd_done && new_lines < 3) m_active = 1'b0;
            m_lines = new_lines;
        end
    end

    // Present pixels one at a time, holding each until accepted.
    task automatic send_pixels(input int n, input int first_val, input bit rnd_val, input bit rnd_gap);
        for (int i = 0; i < n; i++) begin
            int waited;
            if (rnd_gap && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            pix_data  = rnd_val ? 8'($urandom_range(0, 255)) : 8'(first_val + i);
            waited = 0;
            forever begin
                @(negedge clk);
                if (pix_ready) break;
                waited++;
                if (waited > 2000) begin
                    check_eq("pix_accept_timeout", pix_ready, 1'b1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_windows(input int n, input int limit);
        int k;
        k = 0;
        while (log_data.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (log_data.size() < n) check_eq("window_timeout", log_data.size(), n);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; win_ready = 1'b0;
        m_both = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_ready", pix_ready, 1'b1);
        check_eq("reset_valid", win_valid, 1'b0);
        check_eq("reset_data", win_data, 72'd0);

        // ---- Three lines back to back, downstream always ready
        win_ready = 1'b1;
        send_pixels(3 * W, 0, 1'b0, 1'b0);
        wait_windows(WPL, 200);
        repeat (6) @(negedge clk);
        check_eq("t1_count", log_data.size(), WPL);
        check_eq("t1_intr_count", intr_cnt, 1);
        if (log_data.size() >= WPL) begin
            check_eq("t1_latency", log_cyc[0] - (line3_cyc + 1), 2);
            check_eq("t1_first", log_data[0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
            check_eq("t1_last", log_data[WPL-1], pack9(5, 6, 7, 13, 14, 15, 21, 22, 23));
        end

        // ---- Fill all four buffers with the reader stalled
        do_reset();
        win_ready = 1'b0;
        send_pixels(4 * W, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("t2_full_ready", pix_ready, 1'b0);
        fork
            send_pixels(W, 4 * W, 1'b0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                check_eq("t2_held_ready", pix_ready, 1'b0);
                @(posedge clk); #1;
                win_ready = 1'b1;
            end
        join
        wait_windows(3 * WPL, 400);
        repeat (6) @(negedge clk);
        check_eq("t2_count", log_data.size(), 3 * WPL);
        check_eq("t2_intr_count", intr_cnt, 3);
        if (log_data.size() > WPL) begin
            check_eq("t2_no_bubble", log_cyc[WPL] - log_cyc[WPL-1], 1);
            check_eq("t2_line2_first", log_data[WPL], pack9(8, 9, 10, 16, 17, 18, 24, 25, 26));
        end

        // ---- Downstream ready toggling every cycle
        do_reset();
        win_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    @(posedge clk); #1;
                    win_ready = ~win_ready;
                end
                win_ready = 1'b1;
            end
            begin
                send_pixels(3 * W, 40, 1'b0, 1'b0);
                wait_windows(WPL, 300);
            end
        join
        repeat (6) @(negedge clk);
        check_eq("t3_count", log_data.size(), WPL);
        check_eq("t3_intr_count", intr_cnt, 1);

        // ---- Reset in the middle of a line read
        do_reset();
        win_ready = 1'b1;
        send_pixels(3 * W, 0, 1'b0, 1'b0);
        wait_windows(3, 200);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("t4_rst_valid", win_valid, 1'b0);
        check_eq("t4_rst_intr", intr, 1'b0);
        check_eq("t4_rst_data", win_data, 72'd0);
        check_eq("t4_rst_ready", pix_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_pixels(3 * W, 100, 1'b0, 1'b0);
        wait_windows(WPL, 200);
        repeat (6) @(negedge clk);
        check_eq("t4_count", log_data.size(), WPL);
        if (log_data.size() >= 1)
            check_eq("t4_first", log_data[0], pack9(100, 101, 102, 108, 109, 110, 116, 117, 118));

        // ---- Random data, random gaps, random downstream stalls
        do_reset();
        rnd_done = 1'b0;
        fork
            while (!rnd_done) begin
                @(posedge clk); #1;
                win_ready = ($urandom_range(0, 9) < 7);
            end
            begin
                send_pixels(12 * W, 0, 1'b1, 1'b1);
                rnd_done = 1'b1;
            end
        join
        @(posedge clk); #1;
        win_ready = 1'b1;
        wait_windows(10 * WPL, 600);
        repeat (8) @(negedge clk);
        check_eq("t5_count", log_data.size(), 10 * WPL);
        check_eq("t5_intr_count", intr_cnt, 10);
        $display("info: simultaneous fill/free events observed = %0d", m_both);

        test_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        check_eq("watchdog_done", test_done, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
